// File: rtl/softmax_pkg.sv
// Shared widths, FSM encoding and the exponent-word expansion used by the softmax normaliser.
package softmax_pkg;
  localparam int EXP_W    = 21;
  localparam int POS_W    = 5;
  localparam int MAN_W    = 16;
  localparam int PROB_W   = 16;
  localparam int EXPAND_W = 47;
  localparam int SUM_W    = 51;
  localparam int REM_W    = SUM_W + 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_DIV  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // {pos, man} -> man * 2^(pos-16) as a fixed value with 16 fraction bits
  function automatic logic [EXPAND_W-1:0] expand_exp(input logic [EXP_W-1:0] word);
    logic [EXPAND_W-1:0] full;
    full = {word[MAN_W-1:0], {(EXPAND_W-MAN_W){1'b0}}};
    return full >> (5'd31 - word[EXP_W-1:MAN_W]);
  endfunction
endpackage

// File: rtl/softmax_div_seq.sv
// Sequential restoring divider: q = floor(dividend * 2^16 / divisor), one bit per cycle,
// saturating to all ones when dividend >= divisor and returning 0 for a zero divisor.
module softmax_div_seq
  import softmax_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [EXPAND_W-1:0] dividend,
  input  logic [SUM_W-1:0]    divisor,
  output logic                busy,
  output logic                done,
  output logic [PROB_W-1:0]   quotient
);
  logic [3:0]       step;
  logic             fixed;
  logic [SUM_W-1:0] rem;
  logic [SUM_W-1:0] dsr;
  logic [REM_W-1:0] trial;
  logic             fits;

  // Partial remainder stays below the divisor, so the trial difference is sign-representable
  assign trial = {rem, 1'b0} - {1'b0, dsr};
  assign fits  = !trial[REM_W-1];
  assign done  = busy && (step == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      step     <= '0;
      fixed    <= 1'b0;
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
    end else if (!busy) begin
      if (start) begin
        busy <= 1'b1;
        step <= '0;
        dsr  <= divisor;
        rem  <= SUM_W'(dividend);
        if (divisor == '0) begin
          fixed    <= 1'b1;
          quotient <= '0;
        end else if (SUM_W'(dividend) >= divisor) begin
          fixed    <= 1'b1;
          quotient <= '1;
        end else begin
          fixed    <= 1'b0;
          quotient <= '0;
        end
      end
    end else begin
      step <= step + 4'd1;
      if (done) busy <= 1'b0;
      if (!fixed) begin
        rem      <= fits ? trial[SUM_W-1:0] : {rem[SUM_W-2:0], 1'b0};
        quotient <= {quotient[PROB_W-2:0], fits};
      end
    end
  end
endmodule

// File: rtl/softmax_norm.sv
// Softmax normaliser: buffers a vector of exponent words, accumulates their sum and
// emits each element divided by the sum as an unsigned Q0.16 probability.
module softmax_norm
  import softmax_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROB_W-1:0] out_prob,
  output logic              out_last,
  output logic              busy
);
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] idx;
  logic [SUM_W-1:0] sum;
  logic [EXP_W-1:0] buffer [N];
  logic             accept;
  logic             div_start;
  logic             div_busy;
  logic             div_done;

  assign in_ready  = (state == ST_LOAD);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_OUT);
  assign out_last  = out_valid && (idx == count - ONE);
  assign busy      = !((state == ST_LOAD) && (count == '0));
  // The first DIV cycle hands operands to the divider; the buffer and sum are settled by then
  assign div_start = (state == ST_DIV) && !div_busy;

  always_ff @(posedge clk) begin
    if (accept) buffer[count[IDX_W-1:0]] <= in_exp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOAD;
      count <= '0;
      idx   <= '0;
      sum   <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            sum   <= sum + SUM_W'(expand_exp(in_exp));
            count <= count + ONE;
            if (in_last || (count == LAST_CNT)) begin
              state <= ST_DIV;
              idx   <= '0;
            end
          end
        end
        ST_DIV: begin
          if (div_done) state <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            if (out_last) begin
              count <= '0;
              sum   <= '0;
              idx   <= '0;
              state <= ST_LOAD;
            end else begin
              idx   <= idx + ONE;
              state <= ST_DIV;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  softmax_div_seq u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (expand_exp(buffer[idx[IDX_W-1:0]])),
    .divisor  (sum),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (out_prob)
  );
endmodule

// File: tb/tb_softmax_norm.sv
// Directed self-checking bench for softmax_norm: reset values, probability values,
// saturation, zero sum, latency, backpressure and reset abandonment.
module tb_softmax_norm;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] in_exp = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_prob;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int valid_cyc = 0;
  int hs_cyc = 0;
  int gap = 0;
  int stray = 0;

  localparam logic [20:0] HALF_P16 = {5'd16, 16'h8000};
  localparam logic [20:0] HALF_P17 = {5'd17, 16'h8000};
  localparam logic [20:0] ZERO_P16 = {5'd16, 16'h0000};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  softmax_norm #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prob  (out_prob),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge; returns just after the falling edge following the accept.
  task automatic applyStimulus(input logic [20:0] word, input logic last);
    in_valid = 1'b1;
    in_exp   = word;
    in_last  = last;
    checkValue("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  // Waits for out_valid, checks it, optionally stalls for hold cycles, then completes the handshake.
  task automatic checkOutput(input string tag, input logic [15:0] exp_prob, input logic exp_last, input int hold);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checkValue({tag, "_timeout"}, 32'd0, 32'd1);
      out_ready = 1'b1;
      return;
    end
    valid_cyc = cyc;
    gap       = valid_cyc - hs_cyc;
    checkValue({tag, "_prob"}, 32'(out_prob), 32'(exp_prob));
    checkValue({tag, "_last"}, 32'(out_last), 32'(exp_last));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkValue({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkValue({tag, "_hold_prob"}, 32'(out_prob), 32'(exp_prob));
      checkValue({tag, "_hold_last"}, 32'(out_last), 32'(exp_last));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hs_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    checkValue("rst_in_ready", 32'(in_ready), 32'd1);
    checkValue("rst_out_valid", 32'(out_valid), 32'd0);
    checkValue("rst_out_prob", 32'(out_prob), 32'd0);
    checkValue("rst_out_last", 32'(out_last), 32'd0);
    checkValue("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Four equal halves -> each 1/4, with 17-cycle latency and 17-cycle handshake spacing
    for (int i = 0; i < 4; i++) begin
      applyStimulus(HALF_P16, i == 3);
      if (i == 0) checkValue("a_busy_loading", 32'(busy), 32'd1);
    end
    checkValue("a_in_ready_div", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("a_out", 16'h4000, i == 3, 0);
      if (i == 0) checkValue("a_latency", valid_cyc - accept_cyc, 32'd17);
      else        checkValue("a_spacing", gap, 32'd17);
    end
    checkValue("a_busy_idle", 32'(busy), 32'd0);
    checkValue("a_in_ready_idle", 32'(in_ready), 32'd1);

    // Single element -> quotient of exactly one saturates
    applyStimulus(HALF_P16, 1'b1);
    checkOutput("b_out", 16'hFFFF, 1'b1, 0);
    checkValue("b_latency", valid_cyc - accept_cyc, 32'd17);

    // Values 1 and 2 -> 1/3 and 2/3
    applyStimulus(HALF_P16, 1'b0);
    applyStimulus(HALF_P17, 1'b1);
    checkOutput("c_out0", 16'h5555, 1'b0, 0);
    checkOutput("c_out1", 16'hAAAA, 1'b1, 0);

    // N elements without in_last close the vector at the Nth
    for (int i = 0; i < N; i++) applyStimulus(HALF_P16, 1'b0);
    checkValue("d_in_ready_closed", 32'(in_ready), 32'd0);
    checkValue("d_latency_pending", 32'(out_valid), 32'd0);
    for (int i = 0; i < N; i++) checkOutput("d_out", 16'h2000, i == N - 1, 0);

    // Backpressure on the first output for 10 cycles
    out_ready = 1'b0;
    applyStimulus(HALF_P16, 1'b0);
    applyStimulus(HALF_P17, 1'b1);
    checkOutput("e_out0", 16'h5555, 1'b0, 10);
    checkOutput("e_out1", 16'hAAAA, 1'b1, 0);
    checkValue("e_spacing", gap, 32'd17);

    // Reset in the middle of a divide abandons the vector
    for (int i = 0; i < 3; i++) applyStimulus(HALF_P16, i == 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkValue("f_rst_out_valid", 32'(out_valid), 32'd0);
    checkValue("f_rst_out_prob", 32'(out_prob), 32'd0);
    checkValue("f_rst_out_last", 32'(out_last), 32'd0);
    checkValue("f_rst_busy", 32'(busy), 32'd0);
    checkValue("f_rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    checkValue("f_no_stray_output", stray, 32'd0);

    // All-zero mantissas give a zero sum and zero probabilities
    applyStimulus(ZERO_P16, 1'b0);
    applyStimulus(ZERO_P16, 1'b1);
    checkOutput("g_out0", 16'h0000, 1'b0, 0);
    checkOutput("g_out1", 16'h0000, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
